i2c_target: RTL
===============

# i2c_target

I2C target (responder) for the on-board sensor/control bus. It is the target-side counterpart of the existing I2C master. The block watches SCL/SDA and ACKs its own 7-bit address. It serves a byte-wide register file through the standard pointer-then-data protocol: write, and write-pointer + repeated START + read. The local logic gets a second port into the same register file, plus a pulse for every byte the bus writes.

## Interface

- TARGET_ADDR, 7'h42, 7-bit address this target answers to
- NUM_REGS, 16, register file depth; power of two, 2..256
- AW, log2(NUM_REGS), register index width (derived, not overridden)

- clk_i  in  1  system clock; must be ≥ 20× SCL frequency
- rst_i  in  1  reset; asynchronous, active-high
- scl_io  inout  1  I2C clock; input only, never driven (no clock stretching)
- sda_io  inout  1  I2C data, open-drain: driven 1'b0 or 1'bz only
- loc_we_i  in  1  local write strobe
- loc_waddr_i  in  AW  local write index
- loc_wdata_i  in  8  local write data
- loc_raddr_i  in  AW  local read index
- loc_rdata_o  out  8  registered read of regs[loc_raddr_i], 1-cycle latency
- rx_valid_o  out  1  one-cycle pulse: a bus write landed in a register
- rx_addr_o  out  AW  index written (valid with rx_valid_o)
- rx_data_o  out  8  data written (valid with rx_valid_o)
- busy_o  out  1  high from address match to STOP / repeated START / NACK release

## Operation

- SCL and SDA each pass through a 2-flop synchronizer, then a third flop that holds the previous value for edge detection.
- All bus events are decided from the synchronized values:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Bits are sampled on an SCL rising edge.
  - SDA may change only on an SCL falling edge.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- IDLE: wait for START, then go to ADDR.
- ADDR: shift in 7 address bits plus R/W, MSB first.
  - Match + W: go to ADDR_ACK and pull SDA low for the 9th clock. Next state is PTR.
  - Match + R: go to ADDR_ACK; next state is RDATA.
  - Mismatch: go to IGNORE and never drive SDA.
- PTR: receive 8 bits. ptr is set to the low AW bits of the byte. Go to PTR_ACK (ACK), then WDATA.
- WDATA: receive 8 bits. On the 8th rising edge, write regs[ptr] and pulse rx_valid_o with rx_addr_o = ptr and rx_data_o = byte. Go to WDATA_ACK (ACK). ptr is incremented mod NUM_REGS, then back to WDATA.
- RDATA: on the falling edge that ends the ACK slot, latch shift = regs[ptr] and increment ptr mod NUM_REGS. Drive bit 7 (0 → low, 1 → release), then the next bit on each following falling edge. After 8 bits, release SDA and enter RDATA_ACK.
- RDATA_ACK: sample SDA on the rising edge.
  - 0 (ACK): go to RDATA for the next byte.
  - 1 (NACK): go to IGNORE.
- ACK slot handling: SDA is pulled low on the falling edge after the 8th bit and released on the falling edge after the 9th bit.
- START in any state (repeated START) goes to ADDR. The bit counter resets; ptr is kept.
- STOP in any state goes to IDLE and releases SDA.
- IGNORE: wait for START or STOP only.
- Local write port is always active.
  - Bus write and local write to the same index in the same cycle: the bus write wins.
  - To different indices: both happen.
- Register file resets to all zeros.

## Timing

- Reset values (asynchronous, immediate):
  - SDA released (z).
  - State IDLE; ptr, bit counter and all registers 0.
  - loc_rdata_o = 0, rx_valid_o = 0, rx_addr_o = 0, rx_data_o = 0, busy_o = 0.
- Reset asserted mid-transaction: SDA is released immediately. After release, the block waits for a fresh START; the current transfer is not resumed.
- Bus-event detection latency: 3 clk_i from the pin edge to the internal event.
- SDA drive change: 1 clk_i after the internal falling-edge event.
- Register write and rx_valid_o: asserted in the cycle after the internal 8th rising edge of a WDATA byte. The same cycle updates loc_rdata_o visibility, so the new value is seen 1 cycle later.
- Read data is latched at the falling edge. A local write to regs[ptr] after that point does not affect the byte in flight.
- busy_o:
  - Rises in the cycle the address match is decided.
  - Falls in the cycle STOP is detected, a NACK is sampled, or a repeated START is detected. On a repeated START it re-rises on the next match.
- ptr wrap: NUM_REGS-1 + 1 → 0, for both write and read.

## Test plan

- Write 0x42<<1|0, ptr 0x03, data 0xA5, STOP → three ACKs. regs[3] = 0xA5. rx_valid_o pulses once with rx_addr_o = 3, rx_data_o = 0xA5. loc_raddr_i = 3 then gives 0xA5.
- Local-preload regs[14] = 0x11 and regs[15] = 0x22. Send write 0x42 with ptr 0x0E, repeated START, read 3 bytes (ACK, ACK, NACK) → bytes 0x11, 0x22, 0x00 (wrap to regs[0]). busy_o falls after the NACK.
- Address 0x43 with write 0x55 → SDA never driven low, no rx_valid_o, busy_o stays 0.
- Burst write at ptr 0x0F with bytes 0x01, 0x02 → regs[15] = 0x01, regs[0] = 0x02, two rx_valid_o pulses.
- Bus write and local write to regs[5] in the same cycle (bus 0x77, local 0x99) → regs[5] = 0x77.
- Assert rst_i during the 4th bit of a read byte → SDA released within the same cycle. The next full write transaction is ACKed normally.

Source files
------------

// File: rtl/i2c_target.sv
// I2C target answering TARGET_ADDR: serves a byte register file through pointer-then-data
// transfers and exposes a second local read/write port into the same registers.
module i2c_target #(
  parameter logic [6:0]  TARGET_ADDR = 7'h42,
  parameter int unsigned NUM_REGS    = 16,
  localparam int unsigned AW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  inout  wire           scl_io,
  inout  wire           sda_io,
  input  logic          loc_we_i,
  input  logic [AW-1:0] loc_waddr_i,
  input  logic [7:0]    loc_wdata_i,
  input  logic [AW-1:0] loc_raddr_i,
  output logic [7:0]    loc_rdata_o,
  output logic          rx_valid_o,
  output logic [AW-1:0] rx_addr_o,
  output logic [7:0]    rx_data_o,
  output logic          busy_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
  } state_e;

  state_e        state_q, state_d;
  logic          scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d, scl_prev_q, scl_prev_d;
  logic          sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d, sda_prev_q, sda_prev_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [6:0]    sh_q, sh_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          rw_q, rw_d;
  logic          oe_q, oe_d;
  logic          busy_q, busy_d;
  logic          rx_valid_q, rx_valid_d;
  logic [AW-1:0] rx_addr_q, rx_addr_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic [7:0]    loc_rdata_q, loc_rdata_d;
  logic [7:0]    regs_q [NUM_REGS];
  logic [7:0]    regs_d [NUM_REGS];

  logic          scl_rise, scl_fall, start_c, stop_c, last_bit, bus_we;
  logic [7:0]    byte_c, rd_byte;

  // Open drain: only ever pull low or release.
  assign sda_io = oe_q ? 1'b0 : 1'bz;

  assign loc_rdata_o = loc_rdata_q;
  assign rx_valid_o  = rx_valid_q;
  assign rx_addr_o   = rx_addr_q;
  assign rx_data_o   = rx_data_q;
  assign busy_o      = busy_q;

  assign scl_rise = scl_s2_q & ~scl_prev_q;
  assign scl_fall = ~scl_s2_q & scl_prev_q;
  assign start_c  = scl_s2_q & scl_prev_q & sda_prev_q & ~sda_s2_q;
  assign stop_c   = scl_s2_q & scl_prev_q & ~sda_prev_q & sda_s2_q;
  assign last_bit = (cnt_q == 3'd7);
  assign byte_c   = {sh_q, sda_s2_q};
  assign rd_byte  = regs_q[ptr_q];

  always_comb begin
    scl_s1_d    = scl_io;
    scl_s2_d    = scl_s1_q;
    scl_prev_d  = scl_s2_q;
    sda_s1_d    = sda_io;
    sda_s2_d    = sda_s1_q;
    sda_prev_d  = sda_s2_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    oe_d        = oe_q;
    busy_d      = busy_q;
    rx_valid_d  = 1'b0;
    rx_addr_d   = rx_addr_q;
    rx_data_d   = rx_data_q;
    bus_we      = 1'b0;
    regs_d      = regs_q;
    loc_rdata_d = regs_q[loc_raddr_i];

    if (start_c) begin
      state_d = S_ADDR;
      cnt_d   = 3'd0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (stop_c) begin
      state_d = S_IDLE;
      cnt_d   = 3'd0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: if (scl_rise) begin
          sh_d  = byte_c[6:0];
          cnt_d = cnt_q + 3'd1;
          if (last_bit) begin
            if (byte_c[7:1] == TARGET_ADDR) begin
              state_d = S_ADDR_ACK;
              rw_d    = byte_c[0];
              busy_d  = 1'b1;
            end else begin
              state_d = S_IGNORE;
            end
          end
        end
        // First falling edge pulls SDA low, the next one releases it and ends the slot.
        S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: if (scl_fall) begin
          if (!oe_q) begin
            oe_d = 1'b1;
          end else begin
            cnt_d = 3'd0;
            if (state_q == S_ADDR_ACK && rw_q) begin
              sh_d    = rd_byte[6:0];
              oe_d    = ~rd_byte[7];
              ptr_d   = ptr_q + AW'(1);
              state_d = S_RDATA;
            end else begin
              oe_d    = 1'b0;
              state_d = (state_q == S_ADDR_ACK) ? S_PTR : S_WDATA;
            end
          end
        end
        S_PTR: if (scl_rise) begin
          sh_d  = byte_c[6:0];
          cnt_d = cnt_q + 3'd1;
          if (last_bit) begin
            ptr_d   = byte_c[AW-1:0];
            state_d = S_PTR_ACK;
          end
        end
        S_WDATA: if (scl_rise) begin
          sh_d  = byte_c[6:0];
          cnt_d = cnt_q + 3'd1;
          if (last_bit) begin
            bus_we     = 1'b1;
            rx_valid_d = 1'b1;
            rx_addr_d  = ptr_q;
            rx_data_d  = byte_c;
            ptr_d      = ptr_q + AW'(1);
            state_d    = S_WDATA_ACK;
          end
        end
        S_RDATA: if (scl_fall) begin
          if (last_bit) begin
            oe_d    = 1'b0;
            state_d = S_RDATA_ACK;
          end else begin
            oe_d  = ~sh_q[6];
            sh_d  = {sh_q[5:0], 1'b0};
            cnt_d = cnt_q + 3'd1;
          end
        end
        // A falling edge here can only follow an ACKed 9th clock; NACK leaves earlier.
        S_RDATA_ACK: begin
          if (scl_rise && sda_s2_q) begin
            state_d = S_IGNORE;
            busy_d  = 1'b0;
          end else if (scl_fall) begin
            sh_d    = rd_byte[6:0];
            oe_d    = ~rd_byte[7];
            ptr_d   = ptr_q + AW'(1);
            cnt_d   = 3'd0;
            state_d = S_RDATA;
          end
        end
        S_IDLE, S_IGNORE: ;
        default: state_d = S_IDLE;
      endcase
    end

    // Bus write is applied last so it wins a same-index collision.
    if (loc_we_i) regs_d[loc_waddr_i] = loc_wdata_i;
    if (bus_we)   regs_d[ptr_q]       = byte_c;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_s1_q    <= 1'b0;
      scl_s2_q    <= 1'b0;
      scl_prev_q  <= 1'b0;
      sda_s1_q    <= 1'b0;
      sda_s2_q    <= 1'b0;
      sda_prev_q  <= 1'b0;
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      sh_q        <= 7'd0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_addr_q   <= '0;
      rx_data_q   <= 8'd0;
      loc_rdata_q <= 8'd0;
      regs_q      <= '{default: 8'd0};
    end else begin
      scl_s1_q    <= scl_s1_d;
      scl_s2_q    <= scl_s2_d;
      scl_prev_q  <= scl_prev_d;
      sda_s1_q    <= sda_s1_d;
      sda_s2_q    <= sda_s2_d;
      sda_prev_q  <= sda_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      rx_valid_q  <= rx_valid_d;
      rx_addr_q   <= rx_addr_d;
      rx_data_q   <= rx_data_d;
      loc_rdata_q <= loc_rdata_d;
      regs_q      <= regs_d;
    end
  end

endmodule
